// File: rtl/nonce_dispatcher.sv
// Multi-channel nonce source: one shared sequential counter (or LFSR) handed out round-robin.
// Optional LFSR mode is built only when NONCE_DISPATCH_LFSR_EN is defined.
module nonce_dispatcher #(
   parameter int          NONCE_W   = 32,
   parameter int          NUM_CH    = 4,
   parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      mode,
   input  logic [NONCE_W-1:0]        seed,
   input  logic                      found,
   input  logic [NUM_CH-1:0]         req,
   output logic [NUM_CH-1:0]         nonce_valid,
   output logic [NUM_CH*NONCE_W-1:0] nonce,
   output logic                      busy,
   output logic                      done,
   output logic                      exhausted,
   output logic [31:0]               issued_cnt
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [NONCE_W-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE, EXH} state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [NONCE_W-1:0] cur;
   logic [NONCE_W-1:0] cur_next;
   logic [NONCE_W-1:0] load_val;
   logic               last;
   logic               grant_any;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W-1:0]   ptr_after;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // First requester at or after the pointer, wrapping around the channel list.
   always_comb begin
      int idx;
      grant_any = 1'b0;
      winner    = '0;
      idx       = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!grant_any && req[idx]) begin
            grant_any = 1'b1;
            winner    = PTR_W'(idx);
         end
      end
   end

   assign ptr_after = (int'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;

`ifdef NONCE_DISPATCH_LFSR_EN
   localparam logic [NONCE_W-1:0] TAPS = NONCE_W'(LFSR_TAPS);

   logic               lfsr_mode;
   logic [NONCE_W-1:0] start_val;

   function automatic logic [NONCE_W-1:0] lfsr_step(input logic [NONCE_W-1:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : '0);
   endfunction

   // An all-zero LFSR state would lock up, so a zero seed starts from 1.
   assign load_val = (mode && seed == '0) ? {{(NONCE_W-1){1'b0}}, 1'b1} : seed;
   assign cur_next = lfsr_mode ? lfsr_step(cur) : cur + 1'b1;
   assign last     = lfsr_mode ? (cur_next == start_val) : (cur == ALL_ONES);

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_mode <= 1'b0;
         start_val <= '0;
      end else if (start && state != RUN) begin
         lfsr_mode <= mode;
         start_val <= load_val;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = mode ^ (^LFSR_TAPS);
   assign load_val   = seed;
   assign cur_next   = cur + 1'b1;
   assign last       = (cur == ALL_ONES);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         nonce_valid <= '0;
         nonce       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         exhausted   <= 1'b0;
         issued_cnt  <= '0;
         ptr         <= '0;
         cur         <= '0;
      end else begin
         nonce_valid <= '0;
         case (state)
            IDLE, DONE, EXH: begin
               if (start) begin
                  state      <= RUN;
                  cur        <= load_val;
                  issued_cnt <= '0;
                  ptr        <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  exhausted  <= 1'b0;
               end
            end
            RUN: begin
               if (found) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (grant_any) begin
                  nonce[int'(winner)*NONCE_W +: NONCE_W] <= cur;
                  nonce_valid[winner] <= 1'b1;
                  issued_cnt          <= sat_inc(issued_cnt);
                  cur                 <= cur_next;
                  ptr                 <= ptr_after;
                  // The final value is still delivered on this grant.
                  if (last) begin
                     state     <= EXH;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     exhausted <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher (NONCE_W=8, NUM_CH=4); LFSR vectors apply when
// NONCE_DISPATCH_LFSR_EN is defined.
module tb_nonce_dispatcher;

   localparam int NW = 8;
   localparam int NC = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic             mode;
   logic [NW-1:0]    seed;
   logic             found;
   logic [NC-1:0]    req;
   logic [NC-1:0]    nonce_valid;
   logic [NC*NW-1:0] nonce;
   logic             busy;
   logic             done;
   logic             exhausted;
   logic [31:0]      issued_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   nonce_dispatcher #(.NONCE_W(NW), .NUM_CH(NC)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .seed        (seed),
      .found       (found),
      .req         (req),
      .nonce_valid (nonce_valid),
      .nonce       (nonce),
      .busy        (busy),
      .done        (done),
      .exhausted   (exhausted),
      .issued_cnt  (issued_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NW-1:0] slice(input int k);
      return nonce[k*NW +: NW];
   endfunction

   task automatic expect_grant(input string tag, input logic [NC-1:0] v, input int ch,
                               input logic [NW-1:0] val);
      tick();
      check_val({tag, "_vld"}, 32'(nonce_valid), 32'(v));
      check_val({tag, "_nonce"}, 32'(slice(ch)), 32'(val));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; found = 1'b0; seed = '0; req = '0;
      tick();
      tick();
      check_val("rst_vld", 32'(nonce_valid), 32'h0);
      check_val("rst_nonce", nonce, 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_done", 32'(done), 32'h0);
      check_val("rst_exh", 32'(exhausted), 32'h0);
      check_val("rst_cnt", issued_cnt, 32'h0);

      reset = 1'b0;
      found = 1'b1;
      tick();
      found = 1'b0;
      check_val("idle_found_done", 32'(done), 32'h0);
      check_val("idle_found_busy", 32'(busy), 32'h0);

      // single requester, sequential from 0x10
      seed = 8'h10; req = 4'b0001; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("s1_busy", 32'(busy), 32'h1);
      check_val("s1_start_vld", 32'(nonce_valid), 32'h0);
      expect_grant("s1_a", 4'b0001, 0, 8'h10);
      check_val("s1_cnt1", issued_cnt, 32'd1);
      expect_grant("s1_b", 4'b0001, 0, 8'h11);
      expect_grant("s1_c", 4'b0001, 0, 8'h12);
      check_val("s1_cnt3", issued_cnt, 32'd3);
      req = '0; found = 1'b1;
      tick();
      found = 1'b0;
      check_val("s1_done", 32'(done), 32'h1);

      // all channels requesting, round-robin from seed 0
      seed = 8'h00; req = 4'b1111; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("s2_start_vld", 32'(nonce_valid), 32'h0);
      expect_grant("s2_c0", 4'b0001, 0, 8'h00);
      expect_grant("s2_c1", 4'b0010, 1, 8'h01);
      expect_grant("s2_c2", 4'b0100, 2, 8'h02);
      expect_grant("s2_c3", 4'b1000, 3, 8'h03);
      expect_grant("s2_c0b", 4'b0001, 0, 8'h04);
      req = '0; found = 1'b1;
      tick();
      found = 1'b0;

      // exhaustion at the top of the sequential space
      seed = 8'hFD; req = 4'b0010; start = 1'b1;
      tick();
      start = 1'b0;
      expect_grant("s3_fd", 4'b0010, 1, 8'hFD);
      expect_grant("s3_fe", 4'b0010, 1, 8'hFE);
      expect_grant("s3_ff", 4'b0010, 1, 8'hFF);
      check_val("s3_exh", 32'(exhausted), 32'h1);
      check_val("s3_done", 32'(done), 32'h1);
      check_val("s3_busy", 32'(busy), 32'h0);
      check_val("s3_cnt", issued_cnt, 32'd3);
      tick();
      check_val("s3_after_vld", 32'(nonce_valid), 32'h0);
      check_val("s3_hold1", 32'(slice(1)), 32'hFF);
      check_val("s3_hold0", 32'(slice(0)), 32'h04);
      check_val("s3_exh_stays", 32'(exhausted), 32'h1);

      // start and found together in EXH: start wins; then found mid-run
      seed = 8'h20; req = 4'b0100; start = 1'b1; found = 1'b1;
      tick();
      start = 1'b0; found = 1'b0;
      check_val("s4_busy", 32'(busy), 32'h1);
      check_val("s4_done", 32'(done), 32'h0);
      check_val("s4_exh", 32'(exhausted), 32'h0);
      expect_grant("s4_g", 4'b0100, 2, 8'h20);
      found = 1'b1;
      tick();
      found = 1'b0;
      check_val("s4_found_vld", 32'(nonce_valid), 32'h0);
      check_val("s4_found_done", 32'(done), 32'h1);
      check_val("s4_found_exh", 32'(exhausted), 32'h0);
      check_val("s4_found_busy", 32'(busy), 32'h0);
      check_val("s4_found_cnt", issued_cnt, 32'd1);
      tick();
      check_val("s4_done_novld", 32'(nonce_valid), 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("s4_restart_busy", 32'(busy), 32'h1);
      check_val("s4_restart_cnt", issued_cnt, 32'd0);

      // start during RUN is ignored; grant still happens
      seed = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      check_val("s5_vld", 32'(nonce_valid), 32'b0100);
      check_val("s5_nonce", 32'(slice(2)), 32'h20);
      expect_grant("s5_next", 4'b0100, 2, 8'h21);
      check_val("s5_cnt", issued_cnt, 32'd2);

      // pointer sits at 3 after channel 2; alternate between channels 1 and 3
      req = 4'b1010;
      expect_grant("s6_c3", 4'b1000, 3, 8'h22);
      expect_grant("s6_c1", 4'b0010, 1, 8'h23);
      expect_grant("s6_c3b", 4'b1000, 3, 8'h24);
      req = '0; found = 1'b1;
      tick();
      found = 1'b0;

      // mode=1 with zero seed
      seed = 8'h00; mode = 1'b1; req = 4'b0001; start = 1'b1;
      tick();
      start = 1'b0; mode = 1'b0;
`ifdef NONCE_DISPATCH_LFSR_EN
      expect_grant("lf_1", 4'b0001, 0, 8'h01);
      expect_grant("lf_2", 4'b0001, 0, 8'h03);
      expect_grant("lf_3", 4'b0001, 0, 8'h02);
      check_val("lf_exh", 32'(exhausted), 32'h1);
      check_val("lf_cnt", issued_cnt, 32'd3);
`else
      expect_grant("md_1", 4'b0001, 0, 8'h00);
      expect_grant("md_2", 4'b0001, 0, 8'h01);
      expect_grant("md_3", 4'b0001, 0, 8'h02);
      check_val("md_exh", 32'(exhausted), 32'h0);
      check_val("md_busy", 32'(busy), 32'h1);
      req = '0; found = 1'b1;
      tick();
      found = 1'b0;
`endif

      // reset in RUN with requests pending
      seed = 8'h30; req = 4'b1111; start = 1'b1;
      tick();
      start = 1'b0;
      expect_grant("s7_g", 4'b0001, 0, 8'h30);
      reset = 1'b1;
      tick();
      check_val("s7_rst_vld", 32'(nonce_valid), 32'h0);
      check_val("s7_rst_nonce", nonce, 32'h0);
      check_val("s7_rst_busy", 32'(busy), 32'h0);
      check_val("s7_rst_done", 32'(done), 32'h0);
      check_val("s7_rst_cnt", issued_cnt, 32'h0);
      reset = 1'b0;
      tick();
      check_val("s7_idle_vld", 32'(nonce_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
